// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: assembles WIDTH-bit words from a framed
// serial stream and hands them off through a single valid/ready output slot.
module sipo_rx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             shift_en,
  input  logic             frame_start,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    bcnt, bcnt_nxt;
  logic [WIDTH-1:0] word;
  logic             complete;
  logic             load;

  // After WIDTH shifts the first bit sits at the MSB (MSB_FIRST) or the LSB.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic bit_in);
    if (MSB_FIRST) return {cur[WIDTH-2:0], bit_in};
    else           return {bit_in, cur[WIDTH-1:1]};
  endfunction

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bcnt_nxt  = bcnt;
    complete  = 1'b0;
    word      = shift_in(sreg, data_in);
    case (state)
      IDLE: begin
        if (shift_en && frame_start) begin
          sreg_nxt  = shift_in('0, data_in);
          bcnt_nxt  = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          // A new frame marker wins even on what would be the last bit.
          if (frame_start) begin
            sreg_nxt = shift_in('0, data_in);
            bcnt_nxt = CW'(1);
          end else if (bcnt == LAST) begin
            complete  = 1'b1;
            sreg_nxt  = word;
            bcnt_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            sreg_nxt = word;
            bcnt_nxt = bcnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The output slot is free if empty or being drained this same cycle.
  assign load = complete && (!data_valid || data_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bcnt       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bcnt    <= bcnt_nxt;
      busy    <= (state_nxt == SHIFT);
      overrun <= complete && data_valid && !data_ready;
      if (load) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: one MSB-first and one LSB-first instance share
// the same serial stream and are checked against hand-computed words.
module tb_sipo_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_in = 1'b0;
  logic       shift_en = 1'b0;
  logic       frame_start = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] out_m, out_l;
  logic       dv_m, dv_l, ov_m, ov_l, bz_m, bz_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .shift_en(shift_en),
    .frame_start(frame_start), .data_ready(data_ready),
    .data_out(out_m), .data_valid(dv_m), .overrun(ov_m), .busy(bz_m)
  );

  sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .shift_en(shift_en),
    .frame_start(frame_start), .data_ready(data_ready),
    .data_out(out_l), .data_valid(dv_l), .overrun(ov_l), .busy(bz_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] exp_m, input logic [7:0] exp_l,
                         input logic dv, input logic ov, input logic bz);
    chk({tag, "/out_msb"}, 32'(out_m), 32'(exp_m));
    chk({tag, "/out_lsb"}, 32'(out_l), 32'(exp_l));
    chk({tag, "/valid_msb"}, 32'(dv_m), 32'(dv));
    chk({tag, "/valid_lsb"}, 32'(dv_l), 32'(dv));
    chk({tag, "/overrun_msb"}, 32'(ov_m), 32'(ov));
    chk({tag, "/overrun_lsb"}, 32'(ov_l), 32'(ov));
    chk({tag, "/busy_msb"}, 32'(bz_m), 32'(bz));
    chk({tag, "/busy_lsb"}, 32'(bz_l), 32'(bz));
  endtask

  task automatic idle(input int n);
    shift_en    = 1'b0;
    frame_start = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    data_in     = b;
    shift_en    = 1'b1;
    frame_start = fs;
    @(posedge clk);
    #1;
    shift_en    = 1'b0;
    frame_start = 1'b0;
  endtask

  // Sends value[7] first; data_ready is raised only on the final bit.
  task automatic send_word(input logic [7:0] value, input int gap, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
      data_ready = (i == 0) ? rdy_last : 1'b0;
      send_bit(value[i], i == 7);
      data_ready = 1'b0;
      if (gap > 0 && i > 0) idle(gap);
    end
  endtask

  task automatic drain();
    data_ready = 1'b1;
    idle(1);
    data_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] w;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic word 0x0F stream, consumer not ready.
    w = 8'h0F;
    send_bit(w[7], 1'b1);
    chk_all("first_bit", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 6; i >= 1; i--) send_bit(w[i], 1'b0);
    chk_all("seven_bits", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    send_bit(w[0], 1'b0);
    chk_all("word_0f", 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0);

    // Second word while slot is full: dropped with overrun pulse.
    send_word(8'hFF, 0, 1'b0);
    chk_all("overrun", 8'h0F, 8'hF0, 1'b1, 1'b1, 1'b0);
    idle(1);
    chk_all("overrun_end", 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0);

    drain();
    chk_all("drain", 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);
    drain();
    chk_all("ready_no_valid", 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with ready on the second completion cycle.
    send_word(8'hFF, 0, 1'b0);
    chk_all("b2b_first", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    send_word(8'h00, 0, 1'b1);
    chk_all("b2b_second", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    drain();

    // Stray bits in IDLE, then gapped 0xA5.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk_all("idle_ignore", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    send_word(8'hA5, 3, 1'b0);
    chk_all("gapped_a5", 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0);
    drain();

    // Restart after 5 bits.
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk_all("partial5", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1);
    send_word(8'h3C, 0, 1'b0);
    chk_all("restart_3c", 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk_all("restart_hold", 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
    drain();

    // frame_start on the eighth bit takes precedence over completion.
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    chk_all("fs_on_last", 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) send_bit(i == 0, 1'b0);
    chk_all("fs_on_last_word", 8'h81, 8'h81, 1'b1, 1'b0, 1'b0);
    drain();

    // Reset mid-frame and while a word is pending.
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_all("rst_midframe", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 0, 1'b0);
    chk_all("pre_rst_word", 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_all("rst_pending", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    chk_all("post_rst_ignore", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    send_word(8'h81, 0, 1'b0);
    chk_all("post_rst_81", 8'h81, 8'h81, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
